// File: rtl/div_iter_signed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constant helpers for the iterative signed
//                divider (state encoding, width-dependent constants).
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    // Widest operand the constant helpers below can describe.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // All-ones pattern of the requested width, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] ones_const(input int unsigned w);
        if (w >= MAX_WIDTH)
            ones_const = '1;
        else
            ones_const = (64'd1 << w) - 64'd1;
    endfunction

    // Most negative two's-complement value of the requested width.
    function automatic logic [MAX_WIDTH-1:0] min_const(input int unsigned w);
        min_const = 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_signed_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_signed_if
//  Description : Request/result bundle between the ID/EX issue logic (master)
//                and the divider (slave).
//                master drives : start, is_signed, a, b, cancel
//                slave drives  : q, r, busy, done, dbz
//  Revision    : 1.0  initial release
// ============================================================================
interface div_iter_signed_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, is_signed, a, b, cancel,
        input  q, r, busy, done, dbz
    );

    modport slave (
        input  start, is_signed, a, b, cancel,
        output q, r, busy, done, dbz
    );
endinterface
`default_nettype wire

// File: rtl/div_iter_signed_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One restoring-division iteration (purely combinational).
//                rem      in  WIDTH  partial remainder (always < divisor)
//                dvd_msb  in  1      next dividend bit shifted in
//                divisor  in  WIDTH  divisor magnitude
//                next_rem out WIDTH  updated partial remainder
//                q_bit    out 1      quotient bit produced this iteration
//  Revision    : 1.0  initial release
// ============================================================================
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic             dvd_msb,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] next_rem,
    output logic                  q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {rem, dvd_msb};
    assign w_trial = w_shift - {1'b0, divisor};

    // Because rem < divisor, w_shift < 2*divisor, so the MSB of the
    // WIDTH+1-bit difference is a reliable "shift < divisor" indicator, and
    // when restoring, w_shift itself already fits in WIDTH bits.
    always_comb begin
        q_bit    = ~w_trial[WIDTH];
        next_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/div_iter_signed.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_signed
//  Description : Iterative restoring divider for DIV/DIVU, one quotient bit
//                per cycle. Operands are converted to magnitudes on start,
//                divided unsigned, then sign-corrected in a final FIX cycle.
//                clock   in  system clock (rising edge)
//                resetn  in  asynchronous active-low reset
//                bus     slave side of div_iter_signed_if
//                        (start/is_signed/a/b/cancel in; q/r/busy/done/dbz out)
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter_signed
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    div_iter_signed_if.slave bus
);

    localparam logic [WIDTH-1:0] c_ONES = WIDTH'(ones_const(WIDTH));
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;      // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_a_orig;   // raw dividend, reported as r on divide-by-zero
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_next_rem;
    logic             w_q_bit;

    // Negating MIN yields MIN again, which read as unsigned is exactly its
    // magnitude, so MIN/-1 naturally produces the wrapped quotient.
    assign w_a_neg = bus.is_signed & bus.a[WIDTH-1];
    assign w_b_neg = bus.is_signed & bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign w_b_mag = w_b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .dvd_msb  (r_dvd[WIDTH-1]),
        .divisor  (r_dvs),
        .next_rem (w_next_rem),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_a_orig <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.cancel) begin
                // Flush beats everything, including a pending FIX or start.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_dvd    <= w_a_mag;
                            r_dvs    <= w_b_mag;
                            r_a_orig <= bus.a;
                            r_sign_q <= w_a_neg ^ w_b_neg;
                            r_sign_r <= w_a_neg;
                            r_zero   <= (bus.b == '0);
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        r_rem <= w_next_rem;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_LAST)
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        if (r_zero) begin
                            r_q   <= c_ONES;
                            r_r   <= r_a_orig;
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= r_sign_q ? (~r_dvd + WIDTH'(1)) : r_dvd;
                            r_r   <= r_sign_r ? (~r_rem + WIDTH'(1)) : r_rem;
                            r_dbz <= 1'b0;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_signed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter_signed
//  Description : Self-checking bench for div_iter_signed (WIDTH = 32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter_signed;

    localparam int W = 32;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    div_iter_signed_if #(.WIDTH(W)) bus ();

    div_iter_signed #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Outputs expected to be held from the last completed operation.
    logic [W-1:0] exp_q   = '0;
    logic [W-1:0] exp_r   = '0;
    logic         exp_dbz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic. SV '/' and '%' on signed operands
    // truncate toward zero with the remainder taking the dividend's sign.
    function automatic void model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, tq, tr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[W-1:0];
            r  = tr[W-1:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issue one division; optionally poke a start while busy at iteration
    // poke_at (0 = never). Checks latency, busy span and the results.
    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, input string tag);
        logic [W-1:0] mq, mr;
        logic         mz;
        int           k;
        int           nbusy;
        bit           seen;
        model(sgn, a, b, mq, mr, mz);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.a         = a;
        bus.b         = b;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom);
        nbusy = bus.busy ? 1 : 0;
        seen  = 1'b0;
        for (k = 1; k <= 40; k++) begin
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.a     = $urandom;
                bus.b     = $urandom_range(1, 9);
            end
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            if (k == 5) check({tag, "/q_held"}, 64'(bus.q), 64'(exp_q));
        end
        check({tag, "/latency"}, 64'(k), 64'(W + 1));
        check({tag, "/busy_cycles"}, 64'(nbusy), 64'(W + 1));
        if (seen) begin
            check({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
            check({tag, "/q"},   64'(bus.q),   64'(mq));
            check({tag, "/r"},   64'(bus.r),   64'(mr));
            check({tag, "/dbz"}, 64'(bus.dbz), 64'(mz));
        end
        exp_q   = mq;
        exp_r   = mr;
        exp_dbz = mz;
    endtask

    // Verifies nothing completes for a while and outputs stay as they were.
    task automatic expect_quiet(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check({tag, "/no_done"}, 64'(seen), 64'd0);
        check({tag, "/q_kept"},   64'(bus.q),   64'(exp_q));
        check({tag, "/r_kept"},   64'(bus.r),   64'(exp_r));
        check({tag, "/dbz_kept"}, 64'(bus.dbz), 64'(exp_dbz));
    endtask

    // Start a random operation and cancel it in the cycle after edge at-1.
    task automatic run_cancel(input int at, input string tag);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.is_signed = 1'($urandom);
        bus.a         = $urandom;
        bus.b         = $urandom_range(1, 1000);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (at - 1) begin
            @(posedge clock);
            #1;
        end
        bus.cancel = 1'b1;
        @(posedge clock);
        #1;
        bus.cancel = 1'b0;
        check({tag, "/busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, "/done_low"}, 64'(bus.done), 64'd0);
        expect_quiet(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        int           sel;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cancel    = 1'b0;

        #1;
        check("reset/q",    64'(bus.q),    64'd0);
        check("reset/r",    64'(bus.r),    64'd0);
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/done", 64'(bus.done), 64'd0);
        check("reset/dbz",  64'(bus.dbz),  64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0, "u_ffff_div16");
        run_op(1'b1, -32'sd7, 32'sd2, 0, "s_m7_div2");
        run_op(1'b1, 32'sd7, -32'sd2, 0, "s_7_divm2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_min_divm1");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "u_min_divffff");
        run_op(1'b0, 32'h1234_5678, 32'h0, 0, "u_dbz");
        run_op(1'b1, 32'h1234_5678, 32'h0, 0, "s_dbz");
        run_op(1'b0, 32'd10, 32'd3, 0, "u_10_div3");
        // Issued in the done cycle of the previous op, with a start poked while busy.
        run_op(1'b0, 32'd100, 32'd7, 6, "b2b_100_div7");

        run_cancel(10, "cancel_c10");
        run_cancel(W + 1, "cancel_fix");

        @(negedge clock);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.a      = 32'd50;
        bus.b      = 32'd5;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("idle_cancel_start/busy", 64'(bus.busy), 64'd0);
        expect_quiet("idle_cancel_start");

        // Asynchronous reset in the middle of CALC.
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = 32'd999;
        bus.b     = 32'd4;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst/q",    64'(bus.q),    64'd0);
        check("async_rst/r",    64'(bus.r),    64'd0);
        check("async_rst/busy", 64'(bus.busy), 64'd0);
        check("async_rst/done", 64'(bus.done), 64'd0);
        check("async_rst/dbz",  64'(bus.dbz),  64'd0);
        exp_q   = '0;
        exp_r   = '0;
        exp_dbz = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        run_op(1'b0, 32'd10, 32'd3, 0, "post_rst_10_div3");

        for (int i = 0; i < 60; i++) begin
            rs  = 1'($urandom);
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = W'($urandom_range(1, 15));
                3: begin
                    ra = 32'h8000_0000;
                    rb = $urandom;
                end
                4:       rb = ra;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(rs, ra, rb, ($urandom_range(0, 2) == 0) ? $urandom_range(2, 30) : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
